// File: rtl/uart_cmd_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_packetizer
// Brief    : Frames UART bytes into command words (with inter-byte timeout)
//            and serialises response words into back-to-back UART bytes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_packetizer #(
    parameter int CMD_BYTES   = 2,
    parameter int RESP_BYTES  = 1,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int TO_W        = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_rdy,
    input  logic [7:0]              rx_data,
    output logic                    clr_rx_rdy,
    output logic [8*CMD_BYTES-1:0]  cmd,
    output logic                    cmd_rdy,
    input  logic                    clr_cmd_rdy,
    output logic                    cmd_timeout,
    input  logic [8*RESP_BYTES-1:0] resp,
    input  logic                    snd_resp,
    output logic                    resp_busy,
    output logic                    resp_done,
    output logic                    uart_trmt,
    output logic [7:0]              uart_tx_data,
    input  logic                    uart_tx_done
);

    localparam int c_CMD_W  = 8 * CMD_BYTES;
    localparam int c_RESP_W = 8 * RESP_BYTES;
    localparam int c_IDX_W  = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
    localparam int c_REM_W  = (RESP_BYTES > 1) ? $clog2(RESP_BYTES) : 1;

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(CMD_BYTES - 1);
    localparam logic [c_REM_W-1:0] c_REM_INIT = c_REM_W'(RESP_BYTES - 1);
    localparam logic [TO_W-1:0]    c_TO_LAST  = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic               c_TO_EN    = (TIMEOUT_CYC != 0);

    // ------------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------------
    logic [c_IDX_W-1:0] r_idx;
    logic [TO_W-1:0]    r_to_cnt;
    logic [c_CMD_W-1:0] r_cmd;
    logic               r_cmd_rdy;
    logic [c_CMD_W-1:0] w_asm_next;
    logic               w_first;
    logic               w_last;
    logic               w_expire;

    // Only the lower CMD_BYTES-1 bytes of the assembly register are ever reused.
    generate
        if (CMD_BYTES == 1) begin : g_asm_single
            assign w_asm_next = rx_data;
        end else begin : g_asm_multi
            logic [c_CMD_W-9:0] r_asm;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_asm <= '0;
                end else if (rx_rdy) begin
                    r_asm <= w_asm_next[c_CMD_W-9:0];
                end
            end

            assign w_asm_next = {r_asm, rx_data};
        end
    endgenerate

    assign w_first    = (r_idx == '0);
    assign w_last     = (r_idx == c_IDX_LAST);
    assign w_expire   = c_TO_EN && !w_first && !rx_rdy && (r_to_cnt == c_TO_LAST);
    assign clr_rx_rdy = rx_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_to_cnt <= '0;
            r_cmd    <= '0;
        end else if (rx_rdy) begin
            r_to_cnt <= '0;
            if (w_last) begin
                r_idx <= '0;
                r_cmd <= w_asm_next;
            end else begin
                r_idx <= r_idx + c_IDX_W'(1);
            end
        end else if (w_expire) begin
            r_idx    <= '0;
            r_to_cnt <= '0;
        end else if (!w_first) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // Frame completion outranks the consumer acknowledge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd_rdy <= 1'b0;
        end else if (rx_rdy && w_last) begin
            r_cmd_rdy <= 1'b1;
        end else if ((rx_rdy && w_first) || clr_cmd_rdy) begin
            r_cmd_rdy <= 1'b0;
        end
    end

    assign cmd         = r_cmd;
    assign cmd_rdy     = r_cmd_rdy;
    assign cmd_timeout = w_expire;

    // ------------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } tx_state_t;

    tx_state_t           r_state;
    tx_state_t           w_state_next;
    logic [c_REM_W-1:0]  r_rem;
    logic [c_RESP_W-1:0] r_tx_sr;
    logic [c_RESP_W-1:0] w_sr_shift;
    logic [7:0]          r_tx_data;
    logic                r_done_q;
    logic                r_resp_done;
    logic                w_done_rise;

    // Edge detect so a done level left over from the previous byte is ignored.
    assign w_done_rise = uart_tx_done && !r_done_q;
    assign w_sr_shift  = r_tx_sr << 8;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (snd_resp) begin
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_done_rise) begin
                    w_state_next = (r_rem != '0) ? S_SEND : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rem       <= '0;
            r_tx_sr     <= '0;
            r_tx_data   <= '0;
            r_done_q    <= 1'b0;
            r_resp_done <= 1'b0;
        end else begin
            r_done_q    <= uart_tx_done;
            r_resp_done <= 1'b0;
            if (r_state == S_IDLE && snd_resp) begin
                r_tx_sr   <= resp;
                r_rem     <= c_REM_INIT;
                r_tx_data <= resp[c_RESP_W-1 -: 8];
            end else if (r_state == S_WAIT && w_done_rise) begin
                if (r_rem != '0) begin
                    r_tx_sr   <= w_sr_shift;
                    r_rem     <= r_rem - c_REM_W'(1);
                    r_tx_data <= w_sr_shift[c_RESP_W-1 -: 8];
                end else begin
                    r_resp_done <= 1'b1;
                end
            end
        end
    end

    assign uart_trmt    = (r_state == S_SEND);
    assign resp_busy    = (r_state != S_IDLE);
    assign resp_done    = r_resp_done;
    assign uart_tx_data = r_tx_data;

endmodule
`default_nettype wire
